ahb_subordinate_sram: RTL and testbench

Synthesizable AHB subordinate backed by a flop-based word memory. It is the responder counterpart to ahb_manager_top and replaces the behavioural subordinate model in system-level benches. It supports programmable fixed wait states, byte and halfword lanes, and the two-cycle ERROR response for illegal accesses.

---
 rtl/ahb_subordinate_sram.sv | 149 ++++++++++++++
 tb/tb_ahb_subordinate_sram.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_subordinate_sram.sv
// AHB subordinate backed by a flop word memory, with fixed wait states,
// byte/halfword lanes and the two-cycle ERROR response for illegal accesses.
module ahb_subordinate_sram #(
  parameter int unsigned DATA_WDT    = 32,
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  input  logic                i_hsel,
  input  logic [31:0]         i_haddr,
  input  logic [1:0]          i_htrans,
  input  logic                i_hwrite,
  input  logic [2:0]          i_hsize,
  input  logic [2:0]          i_hburst,
  input  logic [DATA_WDT-1:0] i_hwdata,
  input  logic                i_hready,
  output logic [DATA_WDT-1:0] o_hrdata,
  output logic                o_hready,
  output logic [1:0]          o_hresp
);

  localparam int unsigned NB    = DATA_WDT / 8;
  localparam int unsigned LW    = $clog2(NB);
  localparam int unsigned AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned BYTES = MEM_DEPTH * NB;
  localparam int unsigned CW    = 4;

  if (WAIT_STATES > 15) begin : g_ws_chk
    $fatal(1, "WAIT_STATES must be in 0..15");
  end
  if (DATA_WDT != 32 && DATA_WDT != 64) begin : g_dw_chk
    $fatal(1, "DATA_WDT must be 32 or 64");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  hready_q, hready_d;
  logic [1:0]            hresp_q, hresp_d;
  logic                  write_q;
  logic [AW-1:0]         addr_q;
  logic [NB-1:0]         strb_q;
  logic [DATA_WDT-1:0]   rdata_q;
  logic [DATA_WDT-1:0]   mem_q [MEM_DEPTH];

  logic                  accept_c, illegal_c, legal_acc_c, err_acc_c;
  logic                  complete_c, commit_c, rd_phase_c;
  logic [31:0]           align_mask_c, lane_off_c, lane_cnt_c;
  logic [NB-1:0]         strb_c;
  logic [DATA_WDT-1:0]   rd_word_c, wr_word_c;
  logic                  unused_c;

  assign unused_c = ^{i_hburst, i_htrans[0]};

  // Address-phase decode; only accepted while this block is itself ready.
  assign accept_c     = i_hsel & i_hready & i_htrans[1] & hready_q;
  assign align_mask_c = (32'd1 << i_hsize) - 32'd1;
  assign illegal_c    = (i_haddr >= 32'(BYTES)) || (i_hsize > 3'(LW)) ||
                        ((i_haddr & align_mask_c) != 32'd0);
  assign legal_acc_c  = accept_c & ~illegal_c;
  assign err_acc_c    = accept_c & illegal_c;

  assign complete_c = pend_q & (state_q == ST_IDLE);
  assign commit_c   = complete_c & write_q;
  assign rd_phase_c = pend_q & ~write_q;

  assign lane_off_c = 32'(i_haddr[LW-1:0]);
  assign lane_cnt_c = 32'd1 << i_hsize;
  assign rd_word_c  = mem_q[addr_q];

  for (genvar k = 0; k < NB; k++) begin : g_lane
    assign strb_c[k] = (32'(k) >= lane_off_c) && (32'(k) < lane_off_c + lane_cnt_c);
    assign wr_word_c[8*k +: 8] = strb_q[k] ? i_hwdata[8*k +: 8] : rd_word_c[8*k +: 8];
  end

  assign o_hrdata = rd_phase_c ? rd_word_c : rdata_q;
  assign o_hready = hready_q;
  assign o_hresp  = hresp_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (complete_c) pend_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (err_acc_c) begin
          state_d = ST_ERR1;
          pend_d  = 1'b0;
        end else if (legal_acc_c) begin
          pend_d = 1'b1;
          if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
            cnt_d   = CW'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_IDLE;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    hready_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
    hresp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= 2'b00;
      write_q  <= 1'b0;
      addr_q   <= '0;
      strb_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      if (accept_c) begin
        write_q <= i_hwrite;
        addr_q  <= i_haddr[LW +: AW];
        strb_q  <= strb_c;
      end
      // Hold the last read word; an errored read presents zero.
      if (err_acc_c && !i_hwrite) rdata_q <= '0;
      else if (rd_phase_c)        rdata_q <= rd_word_c;
    end
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[AW'(i)] <= '0;
    end else if (commit_c) begin
      mem_q[addr_q] <= wr_word_c;
    end
  end

endmodule

// File: tb/tb_ahb_subordinate_sram.sv
// Scoreboard bench for ahb_subordinate_sram: one zero-wait and one two-wait
// instance share the bus; a byte-level model predicts every data phase.
module tb_ahb_subordinate_sram;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  int          tgt;

  logic [31:0] rdata0, rdata2, bus_rdata;
  logic        hready0, hready2, bus_hready;
  logic [1:0]  hresp0, hresp2, bus_hresp;
  logic        hsel0, hsel2;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];
  bit          dp = 1'b0;
  int          waits_seen = 0;
  logic [31:0] next_wdata;
  logic [7:0]  mdl [2][256];

  always #5 clk = ~clk;

  assign hsel0      = hsel & (tgt == 0);
  assign hsel2      = hsel & (tgt == 1);
  assign bus_hready = (tgt == 1) ? hready2 : hready0;
  assign bus_hresp  = (tgt == 1) ? hresp2  : hresp0;
  assign bus_rdata  = (tgt == 1) ? rdata2  : rdata0;

  ahb_subordinate_sram #(.DATA_WDT(32), .MEM_DEPTH(64), .WAIT_STATES(0)) u_dut0 (
    .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(hsel0), .i_haddr(haddr),
    .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
    .i_hwdata(hwdata), .i_hready(bus_hready), .o_hrdata(rdata0),
    .o_hready(hready0), .o_hresp(hresp0));

  ahb_subordinate_sram #(.DATA_WDT(32), .MEM_DEPTH(64), .WAIT_STATES(2)) u_dut2 (
    .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(hsel2), .i_haddr(haddr),
    .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
    .i_hwdata(hwdata), .i_hready(bus_hready), .o_hrdata(rdata2),
    .o_hready(hready2), .o_hresp(hresp2));

  // Data-phase tracker: pops the expectation when the selected subordinate completes.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        dp = 1'b0;
        sb_q.delete();
      end else begin
        if (dp) begin
          if (bus_hready !== 1'b1) begin
            waits_seen++;
            if (sb_q.size() > 0) begin
              checks++;
              if (bus_hresp !== sb_q[0].resp) begin
                errors++;
                $display("FAIL sb_stall_resp: hresp %0d, need %0d", bus_hresp, sb_q[0].resp);
              end
            end
          end else begin
            dp = 1'b0;
            checks++;
            if (sb_q.size() == 0) begin
              errors++;
              $display("FAIL sb_underflow: data phase completed, need a queued transfer");
            end else begin
              e = sb_q.pop_front();
              if (bus_hresp !== e.resp) begin
                errors++;
                $display("FAIL sb_resp: hresp %0d, need %0d", bus_hresp, e.resp);
              end
              checks++;
              if (waits_seen != e.waits) begin
                errors++;
                $display("FAIL sb_waits: %0d stall cycles, need %0d", waits_seen, e.waits);
              end
              if (!e.wr) begin
                checks++;
                if (bus_rdata !== e.rdata) begin
                  errors++;
                  $display("FAIL sb_rdata: hrdata %08h, need %08h", bus_rdata, e.rdata);
                end
              end
            end
          end
        end
        if (hsel && bus_hready === 1'b1 && htrans[1]) begin
          dp = 1'b1;
          waits_seen = 0;
        end
      end
    end
  endtask

  // Drive one address phase (previous data phase's hwdata alongside) and model it.
  task automatic bus_op(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [2:0] burst, input logic [31:0] wdata);
    exp_t        e;
    logic        illegal;
    logic [31:0] mask;
    int          n = 0;
    hsel = 1'b1; htrans = trans; hwrite = wr; haddr = addr;
    hsize = size; hburst = burst; hwdata = next_wdata;
    @(negedge clk);
    while (bus_hready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL bus_op_timeout: hready stuck low at addr %08h", addr);
    end
    if (trans[1]) begin
      mask    = (32'd1 << size) - 32'd1;
      illegal = (addr >= 32'd256) || (size > 3'd2) || ((addr & mask) != 32'd0);
      e.wr    = wr;
      e.resp  = illegal ? 2'b01 : 2'b00;
      e.waits = illegal ? 1 : ((tgt == 1) ? 2 : 0);
      e.rdata = 32'd0;
      if (!illegal) begin
        if (wr) begin
          for (int b = 0; b < (1 << size); b++)
            mdl[tgt][int'(addr) + b] = wdata[8*((int'(addr) + b) % 4) +: 8];
        end else begin
          for (int b = 0; b < 4; b++)
            e.rdata[8*b +: 8] = mdl[tgt][int'(addr & ~32'd3) + b];
        end
      end
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    next_wdata = wdata;
  endtask

  task automatic bus_idle();
    int n = 0;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = next_wdata;
    @(negedge clk);
    while (bus_hready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL bus_idle_timeout: hready stuck low");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0;
    hsize = 3'd0; hburst = 3'd0; hwdata = '0; next_wdata = '0;
    for (int t = 0; t < 2; t++)
      for (int a = 0; a < 256; a++) mdl[t][a] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (hready0 !== 1'b1) begin errors++; $display("FAIL reset_hready0: %b, need 1", hready0); end
    if (hresp0 !== 2'b00) begin errors++; $display("FAIL reset_hresp0: %0d, need 0", hresp0); end
    if (rdata0 !== 32'd0) begin errors++; $display("FAIL reset_rdata0: %08h, need 0", rdata0); end
    if (hready2 !== 1'b1) begin errors++; $display("FAIL reset_hready2: %b, need 1", hready2); end
    if (hresp2 !== 2'b00) begin errors++; $display("FAIL reset_hresp2: %0d, need 0", hresp2); end
    if (rdata2 !== 32'd0) begin errors++; $display("FAIL reset_rdata2: %08h, need 0", rdata2); end
  endtask

  task automatic test_zero_wait();
    tgt = 0;
    bus_op(2'b10, 1'b1, 32'h10, 3'd2, 3'd0, 32'hDEADBEEF);
    bus_op(2'b10, 1'b0, 32'h10, 3'd2, 3'd0, 32'h0);
    bus_idle();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL zero_wait_drain: %0d pending, need 0", sb_q.size()); end
  endtask

  task automatic test_wait_burst();
    tgt = 1;
    bus_op(2'b10, 1'b1, 32'h0, 3'd2, 3'd3, 32'd1);
    bus_op(2'b11, 1'b1, 32'h4, 3'd2, 3'd3, 32'd2);
    bus_op(2'b11, 1'b1, 32'h8, 3'd2, 3'd3, 32'd3);
    bus_op(2'b11, 1'b1, 32'hC, 3'd2, 3'd3, 32'd4);
    for (int i = 0; i < 4; i++) bus_op(2'b10, 1'b0, 32'(4 * i), 3'd2, 3'd0, 32'h0);
    bus_idle();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL wait_burst_drain: %0d pending, need 0", sb_q.size()); end
  endtask

  task automatic test_byte_lanes();
    tgt = 0;
    bus_op(2'b10, 1'b1, 32'h20, 3'd2, 3'd0, 32'h11223344);
    bus_op(2'b10, 1'b1, 32'h21, 3'd0, 3'd0, 32'hAAAAAAAA);
    bus_op(2'b10, 1'b0, 32'h20, 3'd2, 3'd0, 32'h0);
    bus_op(2'b10, 1'b1, 32'h22, 3'd1, 3'd0, 32'h55665566);
    bus_op(2'b10, 1'b0, 32'h20, 3'd2, 3'd0, 32'h0);
    bus_op(2'b10, 1'b0, 32'h22, 3'd1, 3'd0, 32'h0);
    bus_idle();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL byte_lanes_drain: %0d pending, need 0", sb_q.size()); end
  endtask

  task automatic test_error_range();
    tgt = 1;
    bus_op(2'b10, 1'b0, 32'h100, 3'd2, 3'd0, 32'h0);
    bus_op(2'b10, 1'b1, 32'h100, 3'd2, 3'd0, 32'hFFFFFFFF);
    bus_op(2'b10, 1'b0, 32'h0, 3'd2, 3'd0, 32'h0);
    bus_idle();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL error_range_drain: %0d pending, need 0", sb_q.size()); end
  endtask

  task automatic test_error_size_align();
    tgt = 0;
    bus_op(2'b10, 1'b1, 32'h0, 3'd2, 3'd0, 32'h13572468);
    bus_op(2'b10, 1'b1, 32'h2, 3'd2, 3'd0, 32'hFFFFFFFF);
    bus_op(2'b10, 1'b1, 32'h0, 3'd3, 3'd0, 32'hFFFFFFFF);
    bus_op(2'b10, 1'b0, 32'h0, 3'd2, 3'd0, 32'h0);
    bus_idle();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL error_size_drain: %0d pending, need 0", sb_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  sz;
    logic [31:0] a;
    for (int t = 0; t < 2; t++) begin
      tgt = t;
      repeat (16) begin
        sz = 3'($urandom_range(0, 2));
        a  = 32'($urandom_range(0, 255)) & ~((32'd1 << sz) - 32'd1);
        if ($urandom_range(0, 5) == 0) a = a + 32'h100;
        bus_op(2'b10, 1'($urandom_range(0, 1)), a, sz, 3'd0, 32'($urandom));
      end
      bus_idle();
      checks++;
      if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d pending, need 0", sb_q.size()); end
    end
  endtask

  task automatic test_reset_mid_wait();
    tgt = 1;
    bus_op(2'b10, 1'b1, 32'h30, 3'd2, 3'd0, 32'hCAFEF00D);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hCAFEF00D;
    checks++;
    if (hready2 !== 1'b0) begin errors++; $display("FAIL mid_wait_stall: hready %b, need 0", hready2); end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (hready2 !== 1'b1) begin errors++; $display("FAIL mid_wait_rst_hready: %b, need 1", hready2); end
    if (hresp2 !== 2'b00) begin errors++; $display("FAIL mid_wait_rst_hresp: %0d, need 0", hresp2); end
    if (rdata2 !== 32'd0) begin errors++; $display("FAIL mid_wait_rst_rdata: %08h, need 0", rdata2); end
    do_reset();
    bus_op(2'b10, 1'b0, 32'h30, 3'd2, 3'd0, 32'h0);
    bus_idle();
    tgt = 0;
    bus_op(2'b10, 1'b0, 32'h10, 3'd2, 3'd0, 32'h0);
    bus_op(2'b10, 1'b0, 32'h20, 3'd2, 3'd0, 32'h0);
    bus_idle();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL mid_wait_drain: %0d pending, need 0", sb_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    tgt   = 0;
    fork
      monitor();
    join_none
    test_reset();
    test_zero_wait();
    test_wait_burst();
    test_byte_lanes();
    test_error_range();
    test_error_size_align();
    test_back_to_back();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
